// File: rtl/lc4_wb_stage.sv
// LC4 writeback/resolve stage: register write port, NZP and carry flags, branch/JSR/RTI redirect
// with wrong-path squash. Defining LC4_WB_PERF_CNT_EN adds retired/squashed event counters.
//
// state  | meaning
// RUN    | normal processing of each valid instruction
// SQUASH | dropping wrong-path instructions; cnt_q counts the ones still to drop
module lc4_wb_stage #(
    parameter int WORD_SIZE    = 256,
    parameter int DADDR        = 4,
    parameter int INSN         = 19,
    parameter int IADDR        = 10,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [INSN:0]        i_insn,
    input  logic [IADDR:0]       i_pc,
    input  logic [WORD_SIZE-1:0] i_alu_result,
    output logic                 o_we,
    output logic [DADDR:0]       o_waddr,
    output logic [WORD_SIZE-1:0] o_wdata,
    output logic [2:0]           o_nzp,
    output logic                 o_carry,
    output logic                 o_redirect,
    output logic [IADDR:0]       o_redirect_pc,
`ifdef LC4_WB_PERF_CNT_EN
    output logic [31:0]          o_retired,
    output logic [31:0]          o_squashed,
`endif
    output logic                 o_illegal
);

    typedef enum logic [0:0] {RUN, SQUASH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [4:0]  opcode;
    logic [DADDR:0] rd;
    logic        is_write, is_tcs, is_jump, is_illegal, br_taken;
    logic        accept, drop, do_write, do_redirect, do_illegal;
    logic        res_n, res_z;
    logic [2:0]  nzp_new;
    logic        unused_in;

    assign opcode    = i_insn[INSN -: 5];
    assign rd        = i_insn[INSN-5 -: DADDR+1];
    assign unused_in = ^{i_pc, i_insn[INSN-6-DADDR:0]};

    assign res_n   = i_alu_result[WORD_SIZE-1];
    assign res_z   = ~|i_alu_result;
    assign nzp_new = {res_n, res_z, ~res_n & ~res_z};

    always_comb begin
        is_write   = 1'b0;
        is_jump    = 1'b0;
        is_illegal = 1'b0;
        br_taken   = 1'b0;
        case (opcode)
            5'b00000: ;
            5'b00001: br_taken = o_nzp[1];
            5'b00010: br_taken = o_nzp[1] | o_nzp[0];
            5'b00011: br_taken = o_nzp[2] | o_nzp[0];
            5'b00100: br_taken = o_nzp[2] | o_nzp[1];
            5'b01000, 5'b01010: is_jump = 1'b1;
            5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01011, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b10000, 5'b10010, 5'b10011, 5'b10100, 5'b10101:
                is_write = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    assign is_tcs      = (opcode == 5'b10100);
    assign accept      = i_valid && (state_q == RUN);
    assign drop        = i_valid && (state_q == SQUASH);
    assign do_write    = accept && is_write;
    assign do_redirect = accept && (is_jump || br_taken);
    assign do_illegal  = accept && is_illegal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (do_redirect && SQUASH_DEPTH != 0) begin
                    state_d = SQUASH;
                    cnt_d   = 3'(SQUASH_DEPTH);
                end
            end
            SQUASH: begin
                if (i_valid) begin
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            o_we          <= 1'b0;
            o_waddr       <= '0;
            o_wdata       <= '0;
            o_nzp         <= 3'b010;
            o_carry       <= 1'b0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_illegal     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_we       <= do_write;
            o_redirect <= do_redirect;
            o_illegal  <= do_illegal;
            if (do_write) begin
                o_waddr <= rd;
                o_wdata <= i_alu_result;
                o_nzp   <= nzp_new;
                if (is_tcs)
                    o_carry <= res_z;
            end
            // Target is held between redirects so fetch can observe it lazily.
            if (do_redirect)
                o_redirect_pc <= i_alu_result[IADDR:0];
        end
    end

`ifdef LC4_WB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_retired  <= '0;
            o_squashed <= '0;
        end else begin
            if (accept)
                o_retired <= o_retired + 32'd1;
            if (drop)
                o_squashed <= o_squashed + 32'd1;
        end
    end
`endif

endmodule

// File: doc/lc4_wb_stage.md
# lc4_wb_stage

Writeback/resolve stage directly downstream of `lc4_alu`. It registers the ALU result into a register-file write port and maintains the NZP condition flags. It also holds the carry flag that feeds the ALU's `carry` input for TCS/TCDH double-word negation, and resolves branches, JSR and RTI into a one-cycle PC redirect. After each taken redirect it squashes wrong-path instructions that are already in flight.

## Interface
- `WORD_SIZE`, 256: datapath width.
- `DADDR`, 4: register address MSB; the address is `[DADDR:0]`.
- `INSN`, 19: instruction MSB.
- `IADDR`, 10: PC MSB.
- `SQUASH_DEPTH`, 2: wrong-path instructions dropped after a redirect. Legal range is 0..7.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: the instruction/result pair below is present this cycle.
- `i_insn` in INSN+1: instruction. Opcode is `[19:15]`, rd is `[14:10]`.
- `i_pc` in IADDR+1: PC of the instruction.
- `i_alu_result` in WORD_SIZE: ALU output for this instruction.
- `o_we` out 1: register write enable.
- `o_waddr` out DADDR+1: write address.
- `o_wdata` out WORD_SIZE: write data.
- `o_nzp` out 3: current flags, ordered {N,Z,P}.
- `o_carry` out 1: carry flag, wired to the ALU `carry` input.
- `o_redirect` out 1: one-cycle pulse requesting a fetch redirect.
- `o_redirect_pc` out IADDR+1: redirect target.
- `o_illegal` out 1: one-cycle pulse for an undefined opcode.

## Operation
**Opcode classes:**
- **Write class:** 00101, 00110, 00111, 01001, 01011, 01100, 01101, 01110, 01111, 10000, 10010, 10011, 10100, 10101.
  - Write `i_alu_result` to rd.
  - Update NZP: N = result[WORD_SIZE-1]; Z = (result == 0); P = !N && !Z. Exactly one flag is set.
- **TCS (10100):** additionally carry ← (result == 0). This lets the following TCDH complete the two's-complement of the high word. No other opcode changes carry.
- **Branches:**
  - BRz (00001) is taken if Z.
  - BRzp (00010) is taken if Z|P.
  - BRnp (00011) is taken if N|P.
  - BRnz (00100) is taken if N|Z.
  - The condition uses the NZP register value before this edge.
  - Target = result[IADDR:0].
- **JSR (01000):** always taken, target = result[IADDR:0].
- **RTI (01010):** always taken, target = result[IADDR:0].
- **Branch/JSR/RTI/NOP (00000):** no write, no flag change.
- **All other opcodes:** `o_illegal` pulses. No write, no flag change, no redirect.

**FSM:**
- **RUN:** normal processing. A taken redirect with SQUASH_DEPTH>0 moves to SQUASH and loads cnt ← SQUASH_DEPTH.
- **SQUASH:**
  - Every `i_valid` input is dropped: no write, no flag or carry update, no redirect, no illegal pulse.
  - cnt decrements per valid input. When the valid input arrives with cnt==1, return to RUN.
  - Cycles with `i_valid`=0 do not decrement.
- With SQUASH_DEPTH=0 the FSM never leaves RUN.
- Inputs with `i_valid`=0 change nothing, and all pulse outputs are 0 for the following cycle.

## Timing
- All outputs are registered. The sampled edge is N; effects are visible after edge N, for exactly one cycle for pulses.
- No backpressure: one instruction per cycle is accepted unconditionally.
- Flags update at the same edge as the write. An instruction at edge N+1 sees flags produced at edge N, so there is no forwarding hazard inside the block.
- Reset values: `o_we`=0, `o_waddr`=0, `o_wdata`=0, `o_nzp`=3'b010, `o_carry`=0, `o_redirect`=0, `o_redirect_pc`=0, `o_illegal`=0, FSM=RUN, cnt=0.
- Reset asserted mid-SQUASH clears the count immediately. The first valid input after `rst_n` rises is processed normally.
- `o_redirect_pc` holds its last value when `o_redirect`=0.

## Configuration
- `LC4_WB_PERF_CNT_EN` defined:
  - Adds outputs `o_retired` (32) and `o_squashed` (32), both reset to 0.
  - `o_retired` increments for each non-squashed valid input, including illegal ones.
  - `o_squashed` increments for each dropped input.
  - Both wrap at 2^32.
- Macro undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset, then idle → `o_nzp`=010, `o_carry`=0, `o_we`=0, no pulses.
- ADD rd=3, result=0x…FF (bit255=1) → next cycle `o_we`=1, `o_waddr`=3, `o_nzp`=100. Then BRz → no redirect. Then BRnz, result=0x045 → `o_redirect`=1, `o_redirect_pc`=0x045.
- TCS, result=0 → `o_carry`=1, `o_nzp`=010. Then TCS, result=5 → `o_carry`=0, `o_nzp`=001.
- JSR, target 0x200, SQUASH_DEPTH=2, then valid ADD, a bubble, valid ADD, valid ADD → the first two ADDs are dropped with no `o_we`, the third writes, and flags change only on the third.
- Reset asserted during SQUASH with cnt=1, then release and a valid ADD → the ADD writes.
- Opcode 11111 → `o_illegal` pulses once, and `o_we`, flags and carry are unchanged. With `LC4_WB_PERF_CNT_EN` defined, `o_retired` is incremented.
